// File: rtl/seq_avg_pkg.sv
// ----------------------------------------------------------------------------
// seq_avg_pkg : shared types and constants for the multicycle averager
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package seq_avg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ACC_HOLD  = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_ADD   = 2'd2,
    ACC_SHIFT = 2'd3
  } acc_op_t;

  localparam int NUM_OPERANDS = 8;
  localparam int SHIFT_STEPS  = 3;
  localparam int ACCWIDTH     = 32;
  localparam int CNT_W        = 3;

endpackage

`default_nettype wire

// File: rtl/seq_avg_datapath.sv
// ----------------------------------------------------------------------------
// seq_avg_datapath : operand store, shared ADD/SHR and accumulator
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_avg_datapath
  import seq_avg_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int ACC_W     = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  acc_op_t              acc_op,
  input  logic [CNT_W-1:0]     cnt,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] d,
  input  logic [DATAWIDTH-1:0] e,
  input  logic [DATAWIDTH-1:0] f,
  input  logic [DATAWIDTH-1:0] g,
  input  logic [DATAWIDTH-1:0] h,
  input  logic [7:0]           sa,
  output logic [ACC_W-1:0]     acc
);

  logic [DATAWIDTH-1:0] ops [NUM_OPERANDS];
  logic [7:0]           sa_reg;
  logic [ACC_W-1:0]     addend;
  logic [ACC_W-1:0]     sum;
  logic [ACC_W-1:0]     shifted;

  assign addend = ACC_W'(ops[cnt]);

  ADD #(.DATAWIDTH(ACC_W)) u_add (
    .a   (acc),
    .b   (addend),
    .sum (sum)
  );

  SHR #(.DATAWIDTH(ACC_W)) u_shr (
    .a      (acc),
    .sh_amt (sa_reg),
    .d      (shifted)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc <= '0;
    end else begin
      case (acc_op)
        ACC_LOAD: begin
          acc    <= '0;
          ops[0] <= a;
          ops[1] <= b;
          ops[2] <= c;
          ops[3] <= d;
          ops[4] <= e;
          ops[5] <= f;
          ops[6] <= g;
          ops[7] <= h;
          sa_reg <= sa;
        end
        ACC_ADD:   acc <= sum;
        ACC_SHIFT: acc <= shifted;
        default:   acc <= acc;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_avg_lib.sv
// ----------------------------------------------------------------------------
// ADD / SHR : component-library adder and logical right shifter
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ADD #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] sum
);
  // Carry-out is intentionally dropped.
  assign sum = a + b;
endmodule

module SHR #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [7:0]           sh_amt,
  output logic [DATAWIDTH-1:0] d
);
  // Amounts at or beyond the width shift everything out, giving zero.
  assign d = a >> sh_amt;
endmodule

`default_nettype wire

// File: rtl/seq_avg_ctrl.sv
// ----------------------------------------------------------------------------
// seq_avg_ctrl : start/busy/done scheduler for the eight-input averager
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_avg_ctrl #(
  parameter int DATAWIDTH = 16,
  parameter int ACCWIDTH  = 32
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] d,
  input  logic [DATAWIDTH-1:0] e,
  input  logic [DATAWIDTH-1:0] f,
  input  logic [DATAWIDTH-1:0] g,
  input  logic [DATAWIDTH-1:0] h,
  input  logic [7:0]           sa,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] avg
);

  import seq_avg_pkg::*;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  acc_op_t            acc_op;
  logic [ACCWIDTH-1:0] acc;
  logic               unused_acc_hi;

  assign unused_acc_hi = ^acc[ACCWIDTH-1:DATAWIDTH];

  // Accumulator command follows the current state so the datapath acts on the same edge.
  always_comb begin
    acc_op = ACC_HOLD;
    case (state)
      IDLE:    if (start) acc_op = ACC_LOAD;
      ACC:     acc_op = ACC_ADD;
      SHIFT:   acc_op = ACC_SHIFT;
      default: acc_op = ACC_HOLD;
    endcase
  end

  seq_avg_datapath #(
    .DATAWIDTH (DATAWIDTH),
    .ACC_W     (ACCWIDTH)
  ) u_datapath (
    .Clk    (Clk),
    .Rst    (Rst),
    .acc_op (acc_op),
    .cnt    (cnt),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .e      (e),
    .f      (f),
    .g      (g),
    .h      (h),
    .sa     (sa),
    .acc    (acc)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      avg   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ACC;
          end
        end
        ACC: begin
          if (cnt == CNT_W'(NUM_OPERANDS - 1)) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == CNT_W'(SHIFT_STEPS - 1)) begin
            cnt   <= '0;
            state <= FIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIN: begin
          avg   <= acc[DATAWIDTH-1:0];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_avg_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seq_avg_ctrl : randomized and directed bench for seq_avg_ctrl
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_seq_avg_ctrl;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0, c = '0, d = '0, e = '0, f = '0, g = '0, h = '0;
  logic [7:0]  sa = '0;
  logic        busy, done;
  logic [15:0] avg;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  seq_avg_ctrl #(.DATAWIDTH(16), .ACCWIDTH(32)) dut (
    .Clk(Clk), .Rst(Rst), .start(start),
    .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
    .sa(sa), .busy(busy), .done(done), .avg(avg)
  );

  // Reference: full sum, then three independent divisions by 2^sa.
  function automatic logic [15:0] model(input logic [15:0] ops [8], input int unsigned s);
    longint unsigned sum = 0;
    for (int i = 0; i < 8; i++) sum += ops[i];
    for (int k = 0; k < 3; k++) sum = (s >= 32) ? 0 : (sum >> s);
    return sum[15:0];
  endfunction

  task automatic set_ops(input logic [15:0] ops [8], input logic [7:0] s);
    a = ops[0]; b = ops[1]; c = ops[2]; d = ops[3];
    e = ops[4]; f = ops[5]; g = ops[6]; h = ops[7];
    sa = s;
  endtask

  // Starts one operation and observes 20 edges after the accept edge.
  task automatic do_op(input logic [15:0] ops [8], input logic [7:0] s,
                       output int lat, output int busy_cnt, output int pulses,
                       output logic [15:0] res);
    lat = -1; busy_cnt = 0; pulses = 0; res = 'x;
    @(negedge Clk);
    set_ops(ops, s);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 20; k++) begin
      @(posedge Clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        pulses++;
        if (lat < 0) begin lat = k; res = avg; end
      end
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || avg !== 16'h0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b avg=%h required 0 0 0000", busy, done, avg);
    end
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] ops [8];
    logic [7:0]  sas [5];
    logic [15:0] vals [5];
    int lat, bc, np;
    logic [15:0] res, exp_v;
    sas  = '{8'd1, 8'd1, 8'd0, 8'd40, 8'd2};
    vals = '{16'h0, 16'hFFFF, 16'h1, 16'h1, 16'd100};
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < 8; i++) ops[i] = (t == 0) ? 16'(i + 1) : vals[t];
      exp_v = model(ops, sas[t]);
      do_op(ops, sas[t], lat, bc, np, res);
      total++;
      if (res !== exp_v) begin
        bad++;
        $display("FAIL directed_avg[%0d]: got %h required %h", t, res, exp_v);
      end
      total++;
      if (lat !== 12 || bc !== 12 || np !== 1) begin
        bad++;
        $display("FAIL directed_timing[%0d]: lat=%0d busy=%0d pulses=%0d required 12 12 1", t, lat, bc, np);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] ops [8];
    logic [7:0]  s;
    int lat, bc, np;
    logic [15:0] res, exp_v;
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 8; i++)
        ops[i] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      s = 8'($urandom_range(0, 40));
      exp_v = model(ops, s);
      do_op(ops, s, lat, bc, np, res);
      total++;
      if (res !== exp_v || lat !== 12 || bc !== 12 || np !== 1) begin
        bad++;
        $display("FAIL random[%0d] sa=%0d: avg=%h lat=%0d busy=%0d pulses=%0d required avg=%h 12 12 1",
                 t, s, res, lat, bc, np, exp_v);
      end
    end
  endtask

  // Second start mid-flight is dropped; start right after done is accepted.
  task automatic test_back_to_back();
    logic [15:0] ops_a [8];
    logic [15:0] ops_x [8];
    logic [15:0] ops_c [8];
    int lat;
    for (int i = 0; i < 8; i++) begin
      ops_a[i] = 16'(i + 1); ops_x[i] = 16'hFFFF; ops_c[i] = 16'd100;
    end
    @(negedge Clk);
    set_ops(ops_a, 8'd1);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 4) begin set_ops(ops_x, 8'd1); start = 1'b1; end
      @(posedge Clk); #1;
      start = 1'b0;
      if (done && lat < 0) begin
        lat = k;
        total++;
        if (avg !== 16'd4 || k !== 12) begin
          bad++;
          $display("FAIL ignore_start: avg=%h at edge %0d required 0004 at 12", avg, k);
        end
        break;
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL ignore_start: no done seen, required done at edge 12");
    end
    set_ops(ops_c, 8'd2);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      @(posedge Clk); #1;
      if (done) begin
        lat = k;
        total++;
        if (avg !== 16'd12 || k !== 12) begin
          bad++;
          $display("FAIL restart_after_done: avg=%h at edge %0d required 000c at 12", avg, k);
        end
      end
    end
    if (lat < 0) begin
      total++; bad++;
      $display("FAIL restart_after_done: no done seen, required done at edge 12");
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ops [8];
    int extra_done, extra_busy;
    for (int i = 0; i < 8; i++) ops[i] = 16'(i + 1);
    @(negedge Clk);
    set_ops(ops, 8'd1);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    repeat (4) @(posedge Clk);
    #1;
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || avg !== 16'h0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b avg=%h required 0 0 0000", busy, done, avg);
    end
    extra_done = 0; extra_busy = 0;
    repeat (20) begin
      @(posedge Clk); #1;
      if (done) extra_done++;
      if (busy) extra_busy++;
    end
    total++;
    if (extra_done !== 0 || extra_busy !== 0) begin
      bad++;
      $display("FAIL reset_mid_quiet: done=%0d busy=%0d cycles required 0 0", extra_done, extra_busy);
    end
  endtask

  task automatic test_rst_start();
    logic [15:0] ops [8];
    int lat, bc, np, seen;
    logic [15:0] res;
    for (int i = 0; i < 8; i++) ops[i] = 16'(i + 1);
    @(negedge Clk);
    set_ops(ops, 8'd1);
    Rst = 1'b1; start = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0; start = 1'b0;
    seen = 0;
    repeat (14) begin
      @(posedge Clk); #1;
      if (busy || done) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rst_start_capture: activity in %0d cycles required 0", seen);
    end
    do_op(ops, 8'd1, lat, bc, np, res);
    total++;
    if (res !== 16'd4 || lat !== 12 || bc !== 12 || np !== 1) begin
      bad++;
      $display("FAIL rst_start_followup: avg=%h lat=%0d busy=%0d pulses=%0d required 0004 12 12 1", res, lat, bc, np);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_rst_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_avg_ctrl.md
# seq_avg_ctrl

Multicycle scheduler for the eight-input averaging datapath. It computes the same result as the combinational tree (sum of eight 16-bit operands, three successive right shifts by `sa`, registered output) using one shared ADD and one shared SHR. A start/busy/done handshake sequences the work. It sits in front of the component library (ADD/SHR/REG) wherever area matters more than throughput.

## Interface

Parameters:
- `DATAWIDTH`, 16, operand and result width
- `ACCWIDTH`, 32, accumulator, adder and shifter width

Ports:
- `Clk`  in  1  sole clock; all state updates on the rising edge
- `Rst`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `a`,`b`,`c`,`d`,`e`,`f`,`g`,`h`  in  DATAWIDTH each  unsigned operands; captured on accept
- `sa`  in  8  unsigned shift amount; captured on accept
- `busy`  out  1  high while an operation is in flight
- `done`  out  1  one-cycle pulse when `avg` is updated
- `avg`  out  DATAWIDTH  result; holds until the next done or reset

## Operation

- States: IDLE, ACC, SHIFT, FIN.
- IDLE, `start`=1: capture a..h into eight operand registers and `sa` into a shift register. Set acc←0, cnt←0, busy←1. Go to ACC.
- ACC: acc←acc + zero-extended operand[cnt], with operand order a,b,…,h. cnt increments. After the 8th add (cnt=7), set cnt←0 and go to SHIFT.
- SHIFT: acc←acc >> sa_reg (logical). After the 3rd shift (cnt=2), go to FIN.
- FIN: avg←acc[DATAWIDTH-1:0] (truncate), done←1, busy←0. Go to IDLE.
- `done` is 0 in every cycle except the one following the FIN edge.
- Arithmetic is unsigned. The maximum sum is 8·(2^16−1) = 524280, which fits in ACCWIDTH, so the adder never overflows. Carry-out is ignored.
- Shift amounts: `sa`≥ACCWIDTH yields acc=0. `sa`=0 leaves acc unchanged. `sa`=1 gives a true average (÷8).
- `start` in any state other than IDLE is ignored, with no queuing. Back-to-back operations therefore need one IDLE cycle, so an operation can start at most every 13 cycles.
- Changes to a..h or `sa` while busy have no effect on the result in flight.
- Reset in any state, including mid-operation: state←IDLE, acc←0, cnt←0, busy←0, done←0, avg←0. Operand registers are don't-care.
- `Rst` and `start` asserted in the same cycle: reset wins and nothing is captured.

## Timing

- Reset values: busy=0, done=0, avg=0.
- Accept edge E0 (IDLE with start=1). Adds occur at E1–E8, shifts at E9–E11, and avg/done are written at E12.
- Latency from accept to done is 12 cycles. `busy` is high for exactly cycles E0+1 through E12, i.e. 12 cycles.
- `avg` changes only at a FIN edge or on reset.
- Exactly one ADD and one SHR instance are active. There is no combinational path from inputs to outputs.

## Structure

- Shared package `seq_avg_pkg`:
  - state enum {IDLE, ACC, SHIFT, FIN}
  - `NUM_OPERANDS`=8, `SHIFT_STEPS`=3, `ACCWIDTH`=32
  - `CNT_W`=3
- Sub-module `seq_avg_datapath` contains:
  - operand registers and the operand mux indexed by cnt
  - a single `ADD #(.DATAWIDTH(ACCWIDTH))` and a single `SHR #(.DATAWIDTH(ACCWIDTH))`
  - the accumulator and its select (load 0 / add / shift / hold)
- The FSM, counter, busy/done and the avg register stay in the top level.

## Test plan

- a..h=1..8, sa=1, start pulse → busy high for 12 cycles; done pulses 12 cycles after accept; avg=4 (36>>3). No other done pulse.
- a..h=0xFFFF, sa=1 → avg=0xFFFF (524280>>3). Confirms no overflow or truncation loss.
- a..h=1 with sa=0 → avg=8. a..h=1 with sa=40 → avg=0. a..h=100 with sa=2 → avg=12 (800>>6).
- After accepting op A (a..h=1..8, sa=1), pulse start again at E4 with a..h changed to 0xFFFF → second start ignored; avg=4; a start in the cycle after done is accepted.
- Rst asserted at E5 of an operation → next cycle busy=0, done=0, avg=0, state IDLE; no done pulse in the following 20 cycles.
- Rst and start high together → nothing accepted; start alone on the next cycle → normal 12-cycle result.
